dac_cmd_sched: RTL and testbench

Round-robin scheduler that shares the single AD5632 serial DAC engine among NREQ requesters on the bpclk domain. It takes a channel/code request and builds the 24-bit DAC frame. It pulses cmd_str to the engine, then tracks engine completion through the engine's chip-select and latch outputs. It keeps a shadow copy of the last code written to each DAC channel and flags a timeout if the engine stalls.

---
 rtl/dac_cmd_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_dac_cmd_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cmd_sched.sv
// Round-robin scheduler sharing one AD5632 serial DAC engine among NREQ requesters.
// Builds the 24-bit write frame, strobes the engine, tracks cs/lt completion and keeps per-channel shadows.

package dac_cmd_sched_pkg;
   localparam int unsigned CODE_W  = 14;
   localparam int unsigned FRAME_W = 32;

   localparam logic [2:0] CMD_WR_INPUT = 3'b000;
   localparam logic [2:0] ADDR_A       = 3'b000;
   localparam logic [2:0] ADDR_B       = 3'b001;

   typedef struct packed {
      logic [7:0]        rsvd_hi;
      logic [1:0]        dont_care;
      logic [2:0]        cmd;
      logic [2:0]        addr;
      logic [CODE_W-1:0] code;
      logic [1:0]        rsvd_lo;
   } dac_frame_t;
endpackage

module dac_cmd_sched
   import dac_cmd_sched_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TMO_CYC = 4096,
   parameter int unsigned TMO_W   = 13
) (
   input  logic                   bpclk,
   input  logic                   lreset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_chan,
   input  logic [CODE_W*NREQ-1:0] req_code,
   output logic [NREQ-1:0]        ack,
   output logic                   done,
   output logic                   busy,
   output logic [FRAME_W-1:0]     cmd_dat,
   output logic                   cmd_str,
   input  logic                   eng_cs,
   input  logic                   eng_lt,
   output logic [CODE_W-1:0]      code_a,
   output logic [CODE_W-1:0]      code_b,
   output logic                   err_tmo
);

   localparam int unsigned     IDX_W    = $clog2(NREQ);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WAIT_CS  = 3'd2,
      ST_WAIT_CSH = 3'd3,
      ST_WAIT_LT  = 3'd4,
      ST_WAIT_END = 3'd5
   } state_t;

   state_t            r_state,   w_state_nxt;
   logic [NREQ-1:0]   r_ack,     w_ack_nxt;
   logic              r_done,    w_done_nxt;
   logic              r_busy,    w_busy_nxt;
   dac_frame_t        r_cmd_dat, w_cmd_dat_nxt;
   logic              r_cmd_str, w_cmd_str_nxt;
   logic [CODE_W-1:0] r_code_a,  w_code_a_nxt;
   logic [CODE_W-1:0] r_code_b,  w_code_b_nxt;
   logic              r_err,     w_err_nxt;
   logic [IDX_W-1:0]  r_rr,      w_rr_nxt;
   logic [TMO_W-1:0]  r_tmo,     w_tmo_nxt;
   logic              r_chan,    w_chan_nxt;
   logic [CODE_W-1:0] r_code,    w_code_nxt;

   logic              w_found;
   logic [IDX_W-1:0]  w_win;
   logic              w_chan_sel;
   logic [CODE_W-1:0] w_code_sel;
   logic              w_in_wait;
   dac_frame_t        w_frame;

   // Rotating priority scan starting at the round-robin pointer
   always_comb begin : arb
      logic [IDX_W-1:0] v_scan;
      w_found    = 1'b0;
      w_win      = '0;
      w_code_sel = '0;
      v_scan     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         v_scan = IDX_W'((32'(r_rr) + k) % NREQ);
         if (!w_found && req[v_scan]) begin
            w_found = 1'b1;
            w_win   = v_scan;
         end
      end
      w_chan_sel = req_chan[w_win];
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (IDX_W'(k) == w_win) begin
            w_code_sel = req_code[k*CODE_W +: CODE_W];
         end
      end
   end

   // Frame for the latched request
   always_comb begin : frame_build
      w_frame           = '0;
      w_frame.cmd       = CMD_WR_INPUT;
      w_frame.addr      = r_chan ? ADDR_B : ADDR_A;
      w_frame.code      = r_code;
   end

   // Next-state and registered-output values
   always_comb begin : fsm_nxt
      w_state_nxt   = r_state;
      w_ack_nxt     = '0;
      w_done_nxt    = 1'b0;
      w_busy_nxt    = r_busy;
      w_cmd_dat_nxt = r_cmd_dat;
      w_cmd_str_nxt = 1'b0;
      w_code_a_nxt  = r_code_a;
      w_code_b_nxt  = r_code_b;
      w_err_nxt     = r_err;
      w_rr_nxt      = r_rr;
      w_tmo_nxt     = r_tmo;
      w_chan_nxt    = r_chan;
      w_code_nxt    = r_code;
      w_in_wait     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt      = ST_ISSUE;
               w_ack_nxt[w_win] = 1'b1;
               w_busy_nxt       = 1'b1;
               w_rr_nxt         = IDX_W'((32'(w_win) + 32'd1) % NREQ);
               w_chan_nxt       = w_chan_sel;
               w_code_nxt       = w_code_sel;
            end
         end
         ST_ISSUE: begin
            w_cmd_dat_nxt = w_frame;
            w_cmd_str_nxt = 1'b1;
            w_tmo_nxt     = '0;
            w_state_nxt   = ST_WAIT_CS;
         end
         ST_WAIT_CS: begin
            w_in_wait = 1'b1;
            if (!eng_cs) w_state_nxt = ST_WAIT_CSH;
         end
         ST_WAIT_CSH: begin
            w_in_wait = 1'b1;
            if (eng_cs) w_state_nxt = ST_WAIT_LT;
         end
         ST_WAIT_LT: begin
            w_in_wait = 1'b1;
            if (!eng_lt) w_state_nxt = ST_WAIT_END;
         end
         ST_WAIT_END: begin
            w_in_wait = 1'b1;
            if (eng_lt) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               if (r_chan) w_code_b_nxt = r_code;
               else        w_code_a_nxt = r_code;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase

      // Stalled engine: abandon the transfer without completion side effects
      if (w_in_wait) begin
         if (r_tmo == TMO_LAST) begin
            w_state_nxt  = ST_IDLE;
            w_busy_nxt   = 1'b0;
            w_err_nxt    = 1'b1;
            w_done_nxt   = 1'b0;
            w_code_a_nxt = r_code_a;
            w_code_b_nxt = r_code_b;
         end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
         end
      end
   end

   always_ff @(posedge bpclk or negedge lreset) begin
      if (!lreset) begin
         r_state   <= ST_IDLE;
         r_ack     <= '0;
         r_done    <= 1'b0;
         r_busy    <= 1'b0;
         r_cmd_dat <= '0;
         r_cmd_str <= 1'b0;
         r_code_a  <= '0;
         r_code_b  <= '0;
         r_err     <= 1'b0;
         r_rr      <= '0;
         r_tmo     <= '0;
         r_chan    <= 1'b0;
         r_code    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ack     <= w_ack_nxt;
         r_done    <= w_done_nxt;
         r_busy    <= w_busy_nxt;
         r_cmd_dat <= w_cmd_dat_nxt;
         r_cmd_str <= w_cmd_str_nxt;
         r_code_a  <= w_code_a_nxt;
         r_code_b  <= w_code_b_nxt;
         r_err     <= w_err_nxt;
         r_rr      <= w_rr_nxt;
         r_tmo     <= w_tmo_nxt;
         r_chan    <= w_chan_nxt;
         r_code    <= w_code_nxt;
      end
   end

   assign ack     = r_ack;
   assign done    = r_done;
   assign busy    = r_busy;
   assign cmd_dat = r_cmd_dat;
   assign cmd_str = r_cmd_str;
   assign code_a  = r_code_a;
   assign code_b  = r_code_b;
   assign err_tmo = r_err;

endmodule

// File: tb/tb_dac_cmd_sched.sv
// Scoreboard bench for dac_cmd_sched: directed requests push expected grants/frames/shadows,
// an independent monitor pops and compares whenever ack, cmd_str or done is presented.

module tb_dac_cmd_sched;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned TMO_CYC = 64;
   localparam int unsigned TMO_W   = 7;

   typedef struct packed {
      logic [13:0] a;
      logic [13:0] b;
   } shadow_t;

   logic              bpclk = 1'b0;
   logic              lreset = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ-1:0]   req_chan = '0;
   logic [14*NREQ-1:0] req_code = '0;
   logic [NREQ-1:0]   ack;
   logic              done;
   logic              busy;
   logic [31:0]       cmd_dat;
   logic              cmd_str;
   logic              eng_cs = 1'b1;
   logic              eng_lt = 1'b1;
   logic [13:0]       code_a;
   logic [13:0]       code_b;
   logic              err_tmo;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_ack_cyc = -100;

   logic [NREQ-1:0] q_ack[$];
   logic [31:0]     q_cmd[$];
   shadow_t         q_done[$];

   dac_cmd_sched #(.NREQ(NREQ), .TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) dut (
      .bpclk    (bpclk),
      .lreset   (lreset),
      .req      (req),
      .req_chan (req_chan),
      .req_code (req_code),
      .ack      (ack),
      .done     (done),
      .busy     (busy),
      .cmd_dat  (cmd_dat),
      .cmd_str  (cmd_str),
      .eng_cs   (eng_cs),
      .eng_lt   (eng_lt),
      .code_a   (code_a),
      .code_b   (code_b),
      .err_tmo  (err_tmo)
   );

   initial forever #5 bpclk = ~bpclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: wait bound expired before the required event", name);
   endtask

   task automatic expect_xfer(input logic [NREQ-1:0] a, input logic [31:0] cmd,
                              input bit with_done, input logic [13:0] sa, input logic [13:0] sb);
      shadow_t s;
      q_ack.push_back(a);
      q_cmd.push_back(cmd);
      if (with_done) begin
         s.a = sa;
         s.b = sb;
         q_done.push_back(s);
      end
   endtask

   task automatic set_req(input int idx, input logic chan, input logic [13:0] code);
      req_chan[idx]          = chan;
      req_code[14*idx +: 14] = code;
   endtask

   task automatic wait_ack();
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge bpclk);
         if (|ack) seen = 1'b1;
      end
      if (!seen) bound_fail("ack_wait");
   endtask

   task automatic wait_cmd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge bpclk);
         if (cmd_str) ok = 1'b1;
      end
      if (!ok) bound_fail("cmd_str_wait");
   endtask

   // Well-behaved engine: cs low, cs high, lt low, lt high
   task automatic engine_seq();
      bit ok;
      wait_cmd(ok);
      if (ok) begin
         eng_cs = 1'b0;
         repeat (2) @(negedge bpclk);
         eng_cs = 1'b1;
         repeat (2) @(negedge bpclk);
         eng_lt = 1'b0;
         repeat (2) @(negedge bpclk);
         eng_lt = 1'b1;
      end
   endtask

   task automatic wait_idle();
      bit idle = 1'b0;
      for (int i = 0; i < 40 && !idle; i++) begin
         @(negedge bpclk);
         if (!busy) idle = 1'b1;
      end
      if (!idle) bound_fail("idle_wait");
   endtask

   // Monitor: every presented ack/cmd_str/done must match the next expectation
   initial forever begin
      @(negedge bpclk);
      cyc++;
      if (lreset) begin
         if (|ack) begin
            if (q_ack.size() == 0) bound_fail("unexpected_ack");
            else chk("ack_grant", 32'(ack), 32'(q_ack.pop_front()));
            last_ack_cyc = cyc;
         end
         if (cmd_str) begin
            chk("ack_to_str_latency", 32'(cyc - last_ack_cyc), 32'd1);
            if (q_cmd.size() == 0) bound_fail("unexpected_cmd_str");
            else chk("cmd_dat", cmd_dat, q_cmd.pop_front());
         end
         if (done) begin
            if (q_done.size() == 0) bound_fail("unexpected_done");
            else begin
               shadow_t s;
               s = q_done.pop_front();
               chk("done_code_a", 32'(code_a), 32'(s.a));
               chk("done_code_b", 32'(code_b), 32'(s.b));
               chk("done_busy_low", 32'(busy), 32'd0);
            end
         end
      end
   end

   initial begin
      bit ok;
      int n;

      repeat (3) @(negedge bpclk);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_ack",     32'(ack),     32'd0);
      chk("rst_cmd_str", 32'(cmd_str), 32'd0);
      chk("rst_cmd_dat", cmd_dat,      32'd0);
      chk("rst_code_a",  32'(code_a),  32'd0);
      chk("rst_err_tmo", 32'(err_tmo), 32'd0);
      lreset = 1'b1;
      @(negedge bpclk);

      // Single request, channel A
      expect_xfer(4'b0001, 32'h0000_6AF0, 1'b1, 14'h1ABC, 14'h0000);
      set_req(0, 1'b0, 14'h1ABC);
      req[0] = 1'b1;
      wait_ack();
      req[0] = 1'b0;
      engine_seq();
      wait_idle();

      // Channel B addressing, pointer now at 1
      expect_xfer(4'b0100, 32'h0001_FFFC, 1'b1, 14'h1ABC, 14'h3FFF);
      set_req(2, 1'b1, 14'h3FFF);
      req[2] = 1'b1;
      wait_ack();
      req[2] = 1'b0;
      engine_seq();
      wait_idle();

      // Stalled engine
      expect_xfer(4'b1000, 32'h0000_0554, 1'b0, 14'h0, 14'h0);
      set_req(3, 1'b0, 14'h0155);
      req[3] = 1'b1;
      wait_ack();
      req[3] = 1'b0;
      wait_cmd(ok);
      if (ok) begin
         n = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge bpclk);
            n++;
            if (!busy) break;
         end
         chk("tmo_latency", 32'(n), 32'(TMO_CYC));
      end
      chk("tmo_err_set",   32'(err_tmo), 32'd1);
      chk("tmo_code_a",    32'(code_a),  32'h1ABC);
      chk("tmo_code_b",    32'(code_b),  32'h3FFF);

      // Served after timeout, flag stays set
      expect_xfer(4'b0001, 32'h0001_8004, 1'b1, 14'h1ABC, 14'h2001);
      set_req(0, 1'b1, 14'h2001);
      req[0] = 1'b1;
      wait_ack();
      req[0] = 1'b0;
      engine_seq();
      wait_idle();
      chk("tmo_err_sticky", 32'(err_tmo), 32'd1);

      // Reset while waiting for latch
      expect_xfer(4'b0010, 32'h0000_2AA8, 1'b0, 14'h0, 14'h0);
      set_req(1, 1'b0, 14'h0AAA);
      req[1] = 1'b1;
      wait_ack();
      req[1] = 1'b0;
      wait_cmd(ok);
      eng_cs = 1'b0;
      repeat (2) @(negedge bpclk);
      eng_cs = 1'b1;
      repeat (2) @(negedge bpclk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      lreset = 1'b0;
      #1;
      chk("mid_rst_busy",    32'(busy),    32'd0);
      chk("mid_rst_cmd_str", 32'(cmd_str), 32'd0);
      chk("mid_rst_ack",     32'(ack),     32'd0);
      chk("mid_rst_err_tmo", 32'(err_tmo), 32'd0);
      chk("mid_rst_code_a",  32'(code_a),  32'd0);
      chk("mid_rst_code_b",  32'(code_b),  32'd0);
      repeat (2) @(negedge bpclk);
      lreset = 1'b1;
      @(negedge bpclk);

      // Round robin from requester 0 with all requests held
      expect_xfer(4'b0001, 32'h0000_0044, 1'b1, 14'h0011, 14'h0000);
      expect_xfer(4'b0010, 32'h0001_0088, 1'b1, 14'h0011, 14'h0022);
      expect_xfer(4'b0100, 32'h0000_00CC, 1'b1, 14'h0033, 14'h0022);
      expect_xfer(4'b1000, 32'h0001_0110, 1'b1, 14'h0033, 14'h0044);
      expect_xfer(4'b0001, 32'h0000_0044, 1'b1, 14'h0011, 14'h0044);
      set_req(0, 1'b0, 14'h0011);
      set_req(1, 1'b1, 14'h0022);
      set_req(2, 1'b0, 14'h0033);
      set_req(3, 1'b1, 14'h0044);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack();
         if (k == 4) req = '0;
         engine_seq();
         wait_idle();
      end

      // Requester 1 raised and dropped while busy is never granted
      expect_xfer(4'b0100, 32'h0000_048C, 1'b1, 14'h0123, 14'h0044);
      set_req(2, 1'b0, 14'h0123);
      req[2] = 1'b1;
      wait_ack();
      req[2] = 1'b0;
      req[1] = 1'b1;
      fork
         engine_seq();
         begin
            repeat (4) @(negedge bpclk);
            req[1] = 1'b0;
         end
      join
      wait_idle();
      repeat (10) @(negedge bpclk);
      chk("drop_no_grant_busy", 32'(busy), 32'd0);
      chk("pending_expectations", 32'(q_ack.size() + q_cmd.size() + q_done.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
